bpred_table: RTL and testbench

Parametrised pattern-history table (PHT) for the fetch stage. Holds 2^IDX_W saturating counters of CNT_W bits each. Gives a zero-latency taken/not-taken prediction for the fetch PC index and trains one entry per cycle from resolved branches in execute. Replaces the single-entry 2-bit predictor: it generalises table depth, counter width and update mode, and can optionally hash in global history (gshare).

---
 rtl/bpred_pkg.sv | 21 ++
 rtl/bpred_cnt_next.sv | 31 +++
 rtl/bpred_table.sv | 79 +++++++
 tb/tb_bpred_table.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared pattern-history-table types: update-mode enum, weak-state helpers, counter type.
package bpred_pkg;

    typedef enum logic {
        BPRED_SAT  = 1'b0,
        BPRED_HYST = 1'b1
    } bpred_mode_e;

    localparam int BPRED_CNT_W = 2;
    typedef logic [BPRED_CNT_W-1:0] bpred_cnt_t;

    // Weak-taken is the smallest value whose MSB is set; weak-not-taken sits just below it.
    function automatic int bpred_weak_taken(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic int bpred_weak_ntaken(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bpred_cnt_next.sv
// Combinational next-state of one saturating counter (plain or hysteresis update).
module bpred_cnt_next
    import bpred_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int MODE  = 0
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam bit               HYST   = (MODE == int'(BPRED_HYST));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WT      = CNT_W'(bpred_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] WN      = CNT_W'(bpred_weak_ntaken(CNT_W));

    always_comb begin
        cnt_o = cnt_i;
        // A mispredict from a weak state flips straight to the opposite strong state.
        if (HYST && taken_i && (cnt_i == WN)) begin
            cnt_o = CNT_MAX;
        end else if (HYST && !taken_i && (cnt_i == WT)) begin
            cnt_o = '0;
        end else if (taken_i && (cnt_i != CNT_MAX)) begin
            cnt_o = cnt_i + CNT_W'(1);
        end else if (!taken_i && (cnt_i != '0)) begin
            cnt_o = cnt_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/bpred_table.sv
// Pattern-history table: zero-latency lookup, one trained entry per cycle, no bypass.
// Optional gshare history hashing when BPRED_GSHARE_EN is defined.
module bpred_table
    import bpred_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int MODE  = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_taken,
    output logic             pred_strong,
    output logic [IDX_W-1:0] pred_ghr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [IDX_W-1:0] upd_ghr,
    input  logic             upd_taken
);
    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] tbl_q [DEPTH];
    logic [IDX_W-1:0] eff_p;
    logic [IDX_W-1:0] eff_u;
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_d;

`ifdef BPRED_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    assign ghr_d = {ghr_q[IDX_W-2:0], upd_taken};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ghr_q <= '0;
        end else if (upd_en) begin
            ghr_q <= ghr_d;
        end
    end

    // Training uses the history captured at prediction time, not the live GHR.
    assign eff_p    = pred_idx ^ ghr_q;
    assign eff_u    = upd_idx ^ upd_ghr;
    assign pred_ghr = ghr_q;
`else
    logic [IDX_W-1:0] unused_upd_ghr;

    assign unused_upd_ghr = upd_ghr;
    assign eff_p          = pred_idx;
    assign eff_u          = upd_idx;
    assign pred_ghr       = '0;
`endif

    assign cnt_p       = tbl_q[eff_p];
    assign pred_taken  = cnt_p[CNT_W-1];
    assign pred_strong = (cnt_p == '0) || (cnt_p == '1);

    bpred_cnt_next #(
        .CNT_W (CNT_W),
        .MODE  (MODE)
    ) u_cnt_next (
        .cnt_i   (tbl_q[eff_u]),
        .taken_i (upd_taken),
        .cnt_o   (cnt_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (upd_en) begin
            tbl_q[eff_u] <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bpred_table.sv
// Bench for bpred_table: plain and hysteresis instances share stimulus; scoreboard vs a table model.
module tb_bpred_table;

    localparam int IDX_W = 6;
    localparam int CNT_W = 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam int MASK  = DEPTH - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HALF  = 1 << (CNT_W - 1);
`ifdef BPRED_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    typedef struct packed {
        logic             sat_t;
        logic             sat_s;
        logic             hy_t;
        logic             hy_s;
        logic [IDX_W-1:0] ghr;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             sat_taken, sat_strong, hy_taken, hy_strong;
    logic [IDX_W-1:0] sat_ghr, hy_ghr;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    int m_sat [DEPTH];
    int m_hy  [DEPTH];
    int m_ghr;

    bpred_table #(.IDX_W(IDX_W), .CNT_W(CNT_W), .MODE(0)) u_sat (
        .CLK(CLK), .RST(RST), .pred_idx(pred_idx), .pred_taken(sat_taken),
        .pred_strong(sat_strong), .pred_ghr(sat_ghr), .upd_en(upd_en),
        .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_taken(upd_taken)
    );

    bpred_table #(.IDX_W(IDX_W), .CNT_W(CNT_W), .MODE(1)) u_hyst (
        .CLK(CLK), .RST(RST), .pred_idx(pred_idx), .pred_taken(hy_taken),
        .pred_strong(hy_strong), .pred_ghr(hy_ghr), .upd_en(upd_en),
        .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_taken(upd_taken)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Reference counter rules written directly from the state description.
    function automatic int next_cnt(input int c, input bit t, input bit hyst);
        if (hyst && t && c == HALF - 1) return CMAX;
        if (hyst && !t && c == HALF) return 0;
        if (t) return (c == CMAX) ? c : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_sat[i] = 0;
            m_hy[i]  = 0;
        end
        m_ghr = 0;
    endfunction

    function automatic exp_t model_lookup(input int pidx);
        exp_t e;
        int   ep;
        ep      = GS ? ((pidx ^ m_ghr) & MASK) : (pidx & MASK);
        e.sat_t = (m_sat[ep] >= HALF);
        e.sat_s = (m_sat[ep] == 0) || (m_sat[ep] == CMAX);
        e.hy_t  = (m_hy[ep] >= HALF);
        e.hy_s  = (m_hy[ep] == 0) || (m_hy[ep] == CMAX);
        e.ghr   = GS ? IDX_W'(m_ghr) : '0;
        return e;
    endfunction

    function automatic void compare(input exp_t e);
        check("sat_taken",  int'(sat_taken),  int'(e.sat_t));
        check("sat_strong", int'(sat_strong), int'(e.sat_s));
        check("sat_ghr",    int'(sat_ghr),    int'(e.ghr));
        check("hyst_taken", int'(hy_taken),   int'(e.hy_t));
        check("hyst_strong",int'(hy_strong),  int'(e.hy_s));
        check("hyst_ghr",   int'(hy_ghr),     int'(e.ghr));
    endfunction

    always @(negedge CLK) begin
        if (exp_q.size() > 0) compare(exp_q.pop_front());
    end

    // Drive one cycle of stimulus just after a rising edge; expected lookup is pre-update.
    task automatic step(input int pidx, input bit uen, input int uidx, input int ughr, input bit ut);
        int eu;
        pred_idx  = IDX_W'(pidx);
        upd_en    = uen;
        upd_idx   = IDX_W'(uidx);
        upd_ghr   = IDX_W'(ughr);
        upd_taken = ut;
        exp_q.push_back(model_lookup(pidx));
        if (uen && !RST) begin
            eu        = GS ? ((uidx ^ ughr) & MASK) : (uidx & MASK);
            m_sat[eu] = next_cnt(m_sat[eu], ut, 1'b0);
            m_hy[eu]  = next_cnt(m_hy[eu], ut, 1'b1);
            m_ghr     = ((m_ghr << 1) | int'(ut)) & MASK;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        RST = 1'b1;
        pred_idx = '0; upd_en = 1'b0; upd_idx = '0; upd_ghr = '0; upd_taken = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < DEPTH; i++) step(i, 1'b0, 0, 0, 1'b0);

        // Four taken to idx 5, then idx 5 and its neighbour 6.
        for (int i = 0; i < 4; i++) step(5, 1'b1, 5, 0, 1'b1);
        step(5, 1'b0, 0, 0, 1'b0);
        step(6, 1'b0, 0, 0, 1'b0);

        // idx 9: T,N,T,T,N,N exercises both weak-state jumps in the hysteresis table.
        step(9, 1'b1, 9, 0, 1'b1);
        step(9, 1'b1, 9, 0, 1'b0);
        step(9, 1'b1, 9, 0, 1'b1);
        step(9, 1'b1, 9, 0, 1'b1);
        step(9, 1'b1, 9, 0, 1'b0);
        step(9, 1'b1, 9, 0, 1'b0);
        step(9, 1'b0, 0, 0, 1'b0);

        // Same-cycle lookup/update collision on entry 3.
        step(0, 1'b1, 3, 0, 1'b1);
        step(3, 1'b1, 3, 0, 1'b1);
        step(3, 1'b0, 0, 0, 1'b0);

        // Gshare-style sequence; history must be captured from the predicting lookup.
        step(0, 1'b1, 0, 0, 1'b1);
        step(0, 1'b1, 0, 0, 1'b1);
        step(0, 1'b1, 0, 0, 1'b0);
        step(6, 1'b0, 0, 0, 1'b0);
        step(6, 1'b1, 6, int'(sat_ghr), 1'b1);
        step(6, 1'b0, 0, 0, 1'b0);

        // upd_en low must ignore the other update inputs.
        for (int i = 0; i < 8; i++) step(13, 1'b0, 13, 0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, MASK), 1'($urandom_range(0, 1)),
                 $urandom_range(0, MASK), $urandom_range(0, MASK), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges while an update is pending.
        for (int i = 0; i < 3; i++) step(20, 1'b1, 20, 0, 1'b1);
        pred_idx  = IDX_W'(20);
        upd_en    = 1'b1;
        upd_idx   = IDX_W'(20);
        upd_taken = 1'b0;
        #2;
        RST = 1'b1;
        model_clear();
        #1;
        compare(model_lookup(20));
        pred_idx = IDX_W'(5);
        #1;
        compare(model_lookup(5));
        upd_idx   = IDX_W'(21);
        upd_taken = 1'b1;
        @(posedge CLK);
        #1;
        step(21, 1'b1, 21, 0, 1'b1);
        RST = 1'b0;
        step(21, 1'b0, 0, 0, 1'b0);
        step(20, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, MASK), 1'($urandom_range(0, 1)),
                 $urandom_range(0, MASK), $urandom_range(0, MASK), 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
